// File: rtl/minv_pkg.sv
// Shared definitions for the modular-inverse register controller: word geometry
// and FSM state encoding.
package minv_pkg;

  localparam int unsigned MINV_WORDS  = 8;
  localparam int unsigned MINV_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    READ = 2'd2
  } minv_state_e;

endpackage

// File: rtl/minv_reg_ctrl.sv
// Sequencer for the 256-bit U/T register: word load, 1-bit right shift, and
// rotating readout. Optional shift counter enabled by MINV_REG_CTRL_SHRCNT_EN.
module minv_reg_ctrl
  import minv_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [MINV_WORD_W-1:0] ld_data,
  input  logic                   shr_req,
  input  logic                   shr_bit,
  output logic                   shr_ack,
  input  logic                   rd_req,
  output logic                   rd_valid,
  output logic [MINV_WORD_W-1:0] rd_data,
  input  logic [MINV_WORD_W-1:0] reg_lo,
  output logic                   reg_we,
  output logic                   reg_sel_cyc,
  output logic                   reg_sel_rs,
  output logic                   reg_bit256,
  output logic [MINV_WORD_W-1:0] reg_din,
`ifdef MINV_REG_CTRL_SHRCNT_EN
  output logic [8:0]             shr_cnt,
`endif
  output logic                   busy
);

  localparam logic [2:0] WLAST = 3'(MINV_WORDS - 1);

  minv_state_e state_q, state_d;
  logic [2:0]  wcnt, wcnt_d;
  logic        ld_first;

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt;
    ld_ready    = 1'b0;
    shr_ack     = 1'b0;
    rd_valid    = 1'b0;
    rd_data     = '0;
    reg_we      = 1'b0;
    reg_sel_cyc = 1'b0;
    reg_sel_rs  = 1'b0;
    reg_bit256  = 1'b0;
    reg_din     = '0;
    busy        = 1'b0;
    ld_first    = 1'b0;
    case (state_q)
      IDLE: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          ld_first = 1'b1;
          reg_we   = 1'b1;
          reg_din  = ld_data;
          wcnt_d   = wcnt + 3'd1;
          state_d  = LOAD;
        end else if (rd_req) begin
          wcnt_d  = '0;
          state_d = READ;
        end else if (shr_req) begin
          shr_ack    = 1'b1;
          reg_we     = 1'b1;
          reg_sel_rs = 1'b1;
          reg_bit256 = shr_bit;
        end
      end
      LOAD: begin
        busy     = 1'b1;
        ld_ready = 1'b1;
        if (ld_valid) begin
          reg_we  = 1'b1;
          reg_din = ld_data;
          wcnt_d  = wcnt + 3'd1;
          if (wcnt == WLAST) state_d = IDLE;
        end
      end
      READ: begin
        // Each read cycle rotates one word down so reg_lo presents the next
        // word; eight rotations bring the register back to its original state.
        busy        = 1'b1;
        rd_valid    = 1'b1;
        rd_data     = reg_lo;
        reg_we      = 1'b1;
        reg_sel_cyc = 1'b1;
        wcnt_d      = wcnt + 3'd1;
        if (wcnt == WLAST) state_d = IDLE;
      end
      default: begin
        wcnt_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt    <= '0;
    end else begin
      state_q <= state_d;
      wcnt    <= wcnt_d;
    end
  end

`ifdef MINV_REG_CTRL_SHRCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      shr_cnt <= '0;
    else if (ld_first)
      shr_cnt <= '0;
    else if (shr_ack && (shr_cnt != '1))
      shr_cnt <= shr_cnt + 9'd1;
  end
`endif

endmodule

// File: doc/minv_reg_ctrl.md
MINV_REG_CTRL -- requirements
Module: minv_reg_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port: ld_valid  in  1  load word offered.
REQ-004 SHALL have port: ld_ready  out  1  load word accepted this cycle when high with ld_valid.
REQ-005 SHALL have port: ld_data  in  32  load word, least-significant word first.
REQ-006 SHALL have port: shr_req  in  1  request one 1-bit right shift.
REQ-007 SHALL have port: shr_bit  in  1  bit injected at register bit 255 on shift.
REQ-008 SHALL have port: shr_ack  out  1  shift performed this cycle.
REQ-009 SHALL have port: rd_req  in  1  request readout of all 8 words.
REQ-010 SHALL have port: rd_valid  out  1  rd_data holds a valid word.
REQ-011 SHALL have port: rd_data  out  32  readout word, least-significant first.
REQ-012 SHALL have port: reg_lo  in  32  register bits [31:0] fed back from the 256-bit U/T register.
REQ-013 SHALL have ports: reg_we, reg_sel_cyc, reg_sel_rs, reg_bit256  out  1 each  register controls; reg_din  out  32  register word input.
REQ-014 SHALL have port: busy  out  1  high in LOAD or READ.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, READ with a 3-bit word counter wcnt.
REQ-016 IDLE priority SHALL be ld_valid > rd_req > shr_req; exactly one operation per cycle.
REQ-017 ld_ready SHALL be 1 in IDLE and LOAD, 0 in READ.
REQ-018 Accepted load word: reg_we=1, sel_cyc=0, sel_rs=0, reg_din=ld_data, wcnt increments; IDLE->LOAD on first word.
REQ-019 LOAD SHALL return to IDLE in the cycle after the 8th word (wcnt wraps 7->0); gaps in ld_valid stall without timeout.
REQ-020 shr_req/rd_req SHALL be ignored (no ack) while in LOAD or READ.
REQ-021 Shift (IDLE, shr_req, no ld_valid/rd_req): same-cycle shr_ack=1, reg_we=1, sel_rs=1, reg_bit256=shr_bit; state stays IDLE; back-to-back shifts every cycle allowed.
REQ-022 rd_req in IDLE SHALL enter READ next cycle; READ lasts exactly 8 cycles: rd_valid=1, rd_data=reg_lo, reg_we=1, sel_cyc=1, sel_rs=0; after 8 rotations the register contents are restored; then IDLE.
REQ-023 No backpressure on readout; rd_valid SHALL be 0 outside READ.
REQ-024 When no operation: reg_we=0; reg_sel_*, reg_bit256 and reg_din SHALL be 0.
REQ-025 All outputs SHALL be combinational from state, wcnt and current inputs; no output latency beyond stated.

Reset
REQ-026 On rst: state=IDLE, wcnt=0; outputs then follow REQ-024 (busy=0, rd_valid=0, shr_ack=0, ld_ready=1).
REQ-027 Reset mid-LOAD or mid-READ SHALL abort the operation; register contents are undefined and not cleared.

Configuration
REQ-028 Macro MINV_REG_CTRL_SHRCNT_EN defined: SHALL add output shr_cnt[8:0], cleared on reset and on first load word, incremented per shr_ack, saturating at 511.
REQ-029 Macro undefined: shr_cnt port and logic SHALL be absent; all other behaviour identical.

Structure
REQ-030 Shared package minv_pkg SHALL hold the FSM state encoding, MINV_WORDS=8 and MINV_WORD_W=32.
REQ-031 No sub-module; the word counter and FSM SHALL reside in minv_reg_ctrl.

Verification
REQ-032 Load 0x00000001..0x00000008 back-to-back -> 8 cycles ld_ready=1, reg_we=1, sel_cyc=0; IDLE after 8th; busy 1 during LOAD.
REQ-033 After load, rd_req -> rd_data sequence 0x1..0x8 over 8 cycles, rd_valid=1; second rd_req repeats identical sequence.
REQ-034 Load all-zero, 3 shifts with shr_bit=1 -> readout word 7 = 0xE0000000, others 0; shr_ack each cycle.
REQ-035 ld_valid and shr_req together in IDLE -> load accepted, shr_ack=0; shr_req during READ -> ignored.
REQ-036 rst asserted after 4 load words -> IDLE immediately, wcnt=0, busy=0; next load takes 8 full words.
REQ-037 With MINV_REG_CTRL_SHRCNT_EN: 600 shifts -> shr_cnt=511; new load word -> shr_cnt=0.
